mmio_player_bridge: RTL and testbench
=====================================

Name: mmio_player_bridge

Overview:
Memory-mapped I/O bridge between the processor's data port and the game peripherals. It is the parametrised successor to the single-player virtual-memory decode, and serves:
- DMEM pass-through with write gating.
- Per-player joystick direction registers.
- Per-player x/y position registers.
- A PS/2 key FIFO with status register.

Sits beside dmem in proc_skeleton; drives proc_data_in and feeds player positions to the VGA logic.

Parameters:
NUM_PLAYERS, 2, number of player channels (1..8)
ADDR_W, 17, processor data-address width
DMEM_DEPTH, 4096, addresses below this are physical DMEM
DIR_BASE, 4100, direction register of player p at DIR_BASE+p
KEY_ADDR, 4110, read pops key FIFO
KEY_STAT, 4111, FIFO status; write clears overflow
POS_BASE, 4200, player p x at POS_BASE+2p, y at POS_BASE+2p+1
FIFO_DEPTH, 8, key FIFO entries (power of 2)
INIT_X, 240, reset x position
INIT_Y, 240, reset y position

Ports:
clock  in  1  master clock; all state updates on the falling edge (processor memory phase)
reset  in  1  asynchronous, active-low reset
address_dmem  in  ADDR_W  processor data address
data  in  32  processor store data
wren  in  1  processor store enable
q_dmem  in  32  read data from dmem
dmem_wren  out  1  gated write enable to dmem
proc_data_in  out  32  load data to processor
dir_up, dir_right, dir_down, dir_left  in  NUM_PLAYERS each  per-player direction inputs, already synchronised
ps2_key_pressed  in  1  PS/2 key strobe (level)
ps2_out  in  8  PS/2 scan code
player_x  out  32*NUM_PLAYERS  flattened x positions, player p at [32p+31:32p]
player_y  out  32*NUM_PLAYERS  flattened y positions
key_overflow  out  1  sticky FIFO overflow flag

Behaviour:
- Reset (reset low, asynchronous):
  - player_x = INIT_X and player_y = INIT_Y for all p.
  - All dir_reg = 0.
  - FIFO empty (count 0); key_overflow = 0; ps2 edge register = 0; mmio_rdata = 0.
  - Reset mid-operation discards FIFO contents and any in-flight read.
- dmem_wren:
  - = wren && (address_dmem < DMEM_DEPTH), combinational.
  - MMIO and unmapped stores never reach dmem.
- Direction channels, per player, each falling edge:
  - Exactly one input high: up→1, right→2, down→3, left→4.
  - All low: 0.
  - Two or more high: dir_reg holds its previous value (sticky; no glitch codes).
- Position registers:
  - Store (wren=1) to POS_BASE+2p loads x[p] with data; POS_BASE+2p+1 loads y[p].
  - Value is visible on player_x/player_y after that falling edge.
  - p ≥ NUM_PLAYERS is unmapped.
- Key FIFO:
  - ps2_key_pressed is rising-edge detected via a registered previous value; each rising edge pushes ps2_out.
  - Load (wren=0) at KEY_ADDR pops the head and returns it zero-extended; empty returns 0 and does not pop.
  - Exactly one pop per cycle in which address_dmem==KEY_ADDR and wren=0.
  - Push when full with no pop: byte dropped, key_overflow set.
  - Push and pop in the same cycle when full: both occur, count unchanged, no overflow.
  - Push and pop in the same cycle when empty: pop returns 0, push lands, count becomes 1.
  - Pointers wrap modulo FIFO_DEPTH.
  - Store at KEY_STAT clears key_overflow; a same-cycle overflow event wins.
- KEY_STAT read value: {23'b0, key_overflow, empty, count[6:0]} (count in bits 6:0, empty bit 7, overflow bit 8).
- Read path:
  - proc_data_in = q_dmem when address < DMEM_DEPTH (combinational).
  - Otherwise proc_data_in = mmio_rdata.
  - mmio_rdata is captured on the falling edge of the cycle in which the address is presented with wren=0; valid for the processor's next rising edge.
  - Unmapped loads return 0.
- Store decode for DIR and KEY_ADDR addresses: stores are ignored.
- All arithmetic is unsigned; addresses are compared at full ADDR_W.

Test Plan:
- Reset: release reset → player_x[p]=240, player_y[p]=240, load of 4100 returns 0, KEY_STAT returns 0x080.
- Direction: player 1 right only, load 4101 → 2; then right+up simultaneously, load 4101 → still 2; release all → 0.
- Position: store 300 to 4202 and 77 to 4203 → player_x[1]=300, player_y[1]=77, player 0 unchanged; load 4202 → 300.
- FIFO ordering: push 0x1C, 0x32, 0x23, then four KEY_ADDR loads → 0x1C, 0x32, 0x23, 0; KEY_STAT → 0x080.
- Overflow: 9 pushes with FIFO_DEPTH=8 → key_overflow=1, KEY_STAT=0x108, first eight codes pop in order; store to 4111 → overflow 0.
- Gating and reset: store to 4096 → dmem_wren=0; store to 4095 → dmem_wren=1; assert reset with 3 keys queued → FIFO empty, positions back to 240.

Source files
------------

// File: rtl/mmio_player_bridge.sv
// MMIO bridge between the processor data port, dmem and the game peripherals:
// gated dmem stores, per-player direction/position registers and a PS/2 key FIFO.

module mmio_player_lane #(
    parameter int INIT_X = 240,
    parameter int INIT_Y = 240
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        i_up,
    input  logic        i_right,
    input  logic        i_down,
    input  logic        i_left,
    input  logic        i_wr_x,
    input  logic        i_wr_y,
    input  logic [31:0] i_data,
    output logic [2:0]  o_dir,
    output logic [31:0] o_x,
    output logic [31:0] o_y
);
    logic [2:0]  r_dir;
    logic [31:0] r_x, r_y;

    always_ff @(negedge clock or negedge reset) begin
        if (!reset) begin
            r_dir <= 3'd0;
            r_x   <= 32'(INIT_X);
            r_y   <= 32'(INIT_Y);
        end else begin
            // Conflicting inputs keep the last clean code.
            case ({i_up, i_right, i_down, i_left})
                4'b1000: r_dir <= 3'd1;
                4'b0100: r_dir <= 3'd2;
                4'b0010: r_dir <= 3'd3;
                4'b0001: r_dir <= 3'd4;
                4'b0000: r_dir <= 3'd0;
                default: r_dir <= r_dir;
            endcase
            if (i_wr_x) r_x <= i_data;
            if (i_wr_y) r_y <= i_data;
        end
    end

    assign o_dir = r_dir;
    assign o_x   = r_x;
    assign o_y   = r_y;
endmodule

module mmio_player_bridge #(
    parameter int NUM_PLAYERS = 2,
    parameter int ADDR_W      = 17,
    parameter int DMEM_DEPTH  = 4096,
    parameter int DIR_BASE    = 4100,
    parameter int KEY_ADDR    = 4110,
    parameter int KEY_STAT    = 4111,
    parameter int POS_BASE    = 4200,
    parameter int FIFO_DEPTH  = 8,
    parameter int INIT_X      = 240,
    parameter int INIT_Y      = 240
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic [ADDR_W-1:0]        address_dmem,
    input  logic [31:0]              data,
    input  logic                     wren,
    input  logic [31:0]              q_dmem,
    output logic                     dmem_wren,
    output logic [31:0]              proc_data_in,
    input  logic [NUM_PLAYERS-1:0]   dir_up,
    input  logic [NUM_PLAYERS-1:0]   dir_right,
    input  logic [NUM_PLAYERS-1:0]   dir_down,
    input  logic [NUM_PLAYERS-1:0]   dir_left,
    input  logic                     ps2_key_pressed,
    input  logic [7:0]               ps2_out,
    output logic [32*NUM_PLAYERS-1:0] player_x,
    output logic [32*NUM_PLAYERS-1:0] player_y,
    output logic                     key_overflow
);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;
    localparam logic [ADDR_W-1:0] A_DMEM = ADDR_W'(DMEM_DEPTH);
    localparam logic [ADDR_W-1:0] A_KEY  = ADDR_W'(KEY_ADDR);
    localparam logic [ADDR_W-1:0] A_STAT = ADDR_W'(KEY_STAT);

    logic [NUM_PLAYERS-1:0][2:0]  w_dir;
    logic [NUM_PLAYERS-1:0][31:0] w_x, w_y;
    logic [NUM_PLAYERS-1:0]       w_wr_x, w_wr_y;

    logic [7:0]    r_mem [FIFO_DEPTH];
    logic [PW-1:0] r_rd_ptr, r_wr_ptr;
    logic [CW-1:0] r_count;
    logic          r_ovf, r_ps2_prev;
    logic [31:0]   r_mmio_rdata;

    logic        w_is_dmem, w_push, w_pop, w_wr, w_empty, w_full, w_ovf_set, w_ovf_clr;
    logic [6:0]  w_cnt7;
    logic [31:0] w_rdata;

    assign w_is_dmem    = address_dmem < A_DMEM;
    assign dmem_wren    = wren && w_is_dmem;
    assign proc_data_in = w_is_dmem ? q_dmem : r_mmio_rdata;

    genvar p;
    generate
        for (p = 0; p < NUM_PLAYERS; p++) begin : g_lane
            assign w_wr_x[p] = wren && (address_dmem == ADDR_W'(POS_BASE + 2 * p));
            assign w_wr_y[p] = wren && (address_dmem == ADDR_W'(POS_BASE + 2 * p + 1));
            mmio_player_lane #(.INIT_X(INIT_X), .INIT_Y(INIT_Y)) u_lane (
                .clock   (clock),
                .reset   (reset),
                .i_up    (dir_up[p]),
                .i_right (dir_right[p]),
                .i_down  (dir_down[p]),
                .i_left  (dir_left[p]),
                .i_wr_x  (w_wr_x[p]),
                .i_wr_y  (w_wr_y[p]),
                .i_data  (data),
                .o_dir   (w_dir[p]),
                .o_x     (w_x[p]),
                .o_y     (w_y[p])
            );
        end
    endgenerate

    assign player_x     = w_x;
    assign player_y     = w_y;
    assign key_overflow = r_ovf;

    // A pop on an empty FIFO returns 0 and is not a pop; a push into a full
    // FIFO still lands when the same cycle pops.
    assign w_push    = ps2_key_pressed && !r_ps2_prev;
    assign w_empty   = (r_count == '0);
    assign w_full    = (r_count == CW'(FIFO_DEPTH));
    assign w_pop     = (address_dmem == A_KEY) && !wren && !w_empty;
    assign w_wr      = w_push && (!w_full || w_pop);
    assign w_ovf_set = w_push && w_full && !w_pop;
    assign w_ovf_clr = wren && (address_dmem == A_STAT);
    assign w_cnt7    = 7'(r_count);

    always_comb begin
        w_rdata = '0;
        if (address_dmem == A_KEY)
            w_rdata = w_empty ? 32'd0 : {24'd0, r_mem[r_rd_ptr]};
        else if (address_dmem == A_STAT)
            w_rdata = {23'd0, r_ovf, w_empty, w_cnt7};
        for (int i = 0; i < NUM_PLAYERS; i++) begin
            if (address_dmem == ADDR_W'(DIR_BASE + i))         w_rdata = {29'd0, w_dir[i]};
            if (address_dmem == ADDR_W'(POS_BASE + 2 * i))     w_rdata = w_x[i];
            if (address_dmem == ADDR_W'(POS_BASE + 2 * i + 1)) w_rdata = w_y[i];
        end
    end

    always_ff @(negedge clock or negedge reset) begin
        if (!reset) begin
            r_rd_ptr     <= '0;
            r_wr_ptr     <= '0;
            r_count      <= '0;
            r_ovf        <= 1'b0;
            r_ps2_prev   <= 1'b0;
            r_mmio_rdata <= '0;
        end else begin
            r_ps2_prev <= ps2_key_pressed;
            if (!wren) r_mmio_rdata <= w_rdata;
            if (w_wr)  r_wr_ptr <= r_wr_ptr + PW'(1);
            if (w_pop) r_rd_ptr <= r_rd_ptr + PW'(1);
            case ({w_wr, w_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
            if (w_ovf_set)      r_ovf <= 1'b1;
            else if (w_ovf_clr) r_ovf <= 1'b0;
        end
    end

    always_ff @(negedge clock) begin
        if (w_wr) r_mem[r_wr_ptr] <= ps2_out;
    end
endmodule

// File: tb/tb_mmio_player_bridge.sv
// Randomised scoreboard bench for mmio_player_bridge against a queue-based model.

module tb_mmio_player_bridge;
    localparam int NP = 2, AW = 17, DMEM = 4096, DIRB = 4100, KEYA = 4110, KSTAT = 4111;
    localparam int POSB = 4200, FD = 8, IX = 240, IY = 240;

    logic clock = 1'b0, reset = 1'b0;
    logic [AW-1:0] address_dmem = '0;
    logic [31:0] data = '0, q_dmem = '0;
    logic wren = 1'b0;
    logic dmem_wren;
    logic [31:0] proc_data_in;
    logic [NP-1:0] dir_up = '0, dir_right = '0, dir_down = '0, dir_left = '0;
    logic ps2_key_pressed = 1'b0;
    logic [7:0] ps2_out = '0;
    logic [32*NP-1:0] player_x, player_y;
    logic key_overflow;

    mmio_player_bridge #(
        .NUM_PLAYERS(NP), .ADDR_W(AW), .DMEM_DEPTH(DMEM), .DIR_BASE(DIRB), .KEY_ADDR(KEYA),
        .KEY_STAT(KSTAT), .POS_BASE(POSB), .FIFO_DEPTH(FD), .INIT_X(IX), .INIT_Y(IY)
    ) dut (
        .clock(clock), .reset(reset), .address_dmem(address_dmem), .data(data), .wren(wren),
        .q_dmem(q_dmem), .dmem_wren(dmem_wren), .proc_data_in(proc_data_in),
        .dir_up(dir_up), .dir_right(dir_right), .dir_down(dir_down), .dir_left(dir_left),
        .ps2_key_pressed(ps2_key_pressed), .ps2_out(ps2_out),
        .player_x(player_x), .player_y(player_y), .key_overflow(key_overflow)
    );

    always #5 clock = ~clock;

    // Reference model
    int          m_dir [NP];
    logic [31:0] m_x [NP], m_y [NP];
    logic [7:0]  m_q [$];
    bit          m_ovf, m_prev;
    logic [31:0] sb [$];
    bit          ld_pend;
    int          n_chk = 0, n_pass = 0;

    logic [NP-1:0] h_up = '0, h_rt = '0, h_dn = '0, h_lf = '0;
    logic          h_kp = 1'b0;
    logic [7:0]    h_kc = '0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s actual=%h expected=%h t=%0t", name, act, exp, $time);
    endtask

    function automatic logic [31:0] m_read(input int ai);
        if (ai == KEYA) return (m_q.size() > 0) ? {24'd0, m_q[0]} : 32'd0;
        if (ai == KSTAT)
            return (m_ovf ? 32'd256 : 32'd0) + (m_q.size() == 0 ? 32'd128 : 32'd0) + 32'(m_q.size());
        for (int p = 0; p < NP; p++) begin
            if (ai == DIRB + p)         return 32'(m_dir[p]);
            if (ai == POSB + 2 * p)     return m_x[p];
            if (ai == POSB + 2 * p + 1) return m_y[p];
        end
        return 32'd0;
    endfunction

    task automatic m_reset();
        for (int p = 0; p < NP; p++) begin
            m_dir[p] = 0; m_x[p] = 32'(IX); m_y[p] = 32'(IY);
        end
        m_q.delete();
        m_ovf = 0; m_prev = 0;
    endtask

    // One processor cycle: drive just after the rising edge, DUT acts on the falling edge.
    task automatic step(input logic [AW-1:0] a, input logic w, input logic [31:0] d);
        int ai, n;
        bit push;
        @(posedge clock); #1;
        address_dmem = a; wren = w; data = d; q_dmem = $urandom;
        dir_up = h_up; dir_right = h_rt; dir_down = h_dn; dir_left = h_lf;
        ps2_key_pressed = h_kp; ps2_out = h_kc;
        ai = int'(a);
        if (!w && ai >= DMEM) begin
            sb.push_back(m_read(ai));
            ld_pend = 1;
        end
        for (int p = 0; p < NP; p++) begin
            n = int'(h_up[p]) + int'(h_rt[p]) + int'(h_dn[p]) + int'(h_lf[p]);
            if (n == 0) m_dir[p] = 0;
            else if (n == 1) m_dir[p] = h_up[p] ? 1 : h_rt[p] ? 2 : h_dn[p] ? 3 : 4;
            if (w && ai == POSB + 2 * p)     m_x[p] = d;
            if (w && ai == POSB + 2 * p + 1) m_y[p] = d;
        end
        push = h_kp && !m_prev;
        m_prev = h_kp;
        if (w && ai == KSTAT) m_ovf = 0;
        if (!w && ai == KEYA && m_q.size() > 0) void'(m_q.pop_front());
        if (push) begin
            if (m_q.size() < FD) m_q.push_back(h_kc);
            else m_ovf = 1;
        end
        #1;
        chk("dmem_wren", 32'(dmem_wren), (w && ai < DMEM) ? 32'd1 : 32'd0);
        if (ai < DMEM) chk("dmem_load", proc_data_in, q_dmem);
    endtask

    task automatic push_key(input logic [7:0] c);
        h_kp = 1; h_kc = c; step('0, 0, 0);
        h_kp = 0; step('0, 0, 0);
    endtask

    task automatic do_reset();
        @(posedge clock); #1;
        reset = 0;
        address_dmem = '0; wren = 0;
        h_up = '0; h_rt = '0; h_dn = '0; h_lf = '0; h_kp = 0;
        dir_up = '0; dir_right = '0; dir_down = '0; dir_left = '0; ps2_key_pressed = 0;
        m_reset();
        sb.delete();
        ld_pend = 0;
        repeat (2) @(posedge clock);
        #1 reset = 1;
    endtask

    // Monitor: loads pop the scoreboard on the rising edge after their falling edge.
    always @(posedge clock) begin
        if (reset) begin
            if (ld_pend) begin
                ld_pend = 0;
                if (sb.size() == 0) chk("sb_underflow", 32'd1, 32'd0);
                else chk("mmio_load", proc_data_in, sb.pop_front());
            end
            for (int p = 0; p < NP; p++) begin
                chk("player_x", player_x[32*p +: 32], m_x[p]);
                chk("player_y", player_y[32*p +: 32], m_y[p]);
            end
            chk("key_overflow", 32'(key_overflow), 32'(m_ovf));
        end
    end

    initial begin
        logic [AW-1:0] a;
        m_reset();
        ld_pend = 0;
        do_reset();
        step(AW'(DIRB), 0, 0);
        step(AW'(KSTAT), 0, 0);

        h_rt = 2'b10; step('0, 0, 0); step(AW'(DIRB + 1), 0, 0);
        h_up = 2'b10; step('0, 0, 0); step(AW'(DIRB + 1), 0, 0);
        h_up = '0; h_rt = '0; step('0, 0, 0); step(AW'(DIRB + 1), 0, 0);

        step(AW'(POSB + 2), 1, 300);
        step(AW'(POSB + 3), 1, 77);
        step(AW'(POSB + 2), 0, 0);

        push_key(8'h1C); push_key(8'h32); push_key(8'h23);
        repeat (4) step(AW'(KEYA), 0, 0);
        step(AW'(KSTAT), 0, 0);

        for (int i = 0; i < 9; i++) push_key(8'(8'h40 + i));
        step(AW'(KSTAT), 0, 0);
        repeat (8) step(AW'(KEYA), 0, 0);
        step(AW'(KSTAT), 1, 0);
        step(AW'(KSTAT), 0, 0);

        for (int i = 0; i < 8; i++) push_key(8'(8'h60 + i));
        h_kp = 1; h_kc = 8'h77; step(AW'(KEYA), 0, 0);
        h_kp = 0; step(AW'(KSTAT), 0, 0);
        repeat (9) step(AW'(KEYA), 0, 0);
        h_kp = 1; h_kc = 8'h5A; step(AW'(KEYA), 0, 0);
        h_kp = 0; step(AW'(KSTAT), 0, 0);

        step(AW'(4096), 1, 5);
        step(AW'(4095), 1, 5);

        step(AW'(POSB), 1, 999);
        push_key(8'h11); push_key(8'h12); push_key(8'h13);
        do_reset();
        step(AW'(KSTAT), 0, 0);
        step(AW'(POSB), 0, 0);

        for (int it = 0; it < 900; it++) begin
            case ($urandom_range(0, 9))
                0: a = AW'($urandom_range(0, DMEM - 1));
                1: a = AW'($urandom_range(DMEM - 1, DMEM));
                2, 3: a = AW'(DIRB + $urandom_range(0, NP));
                4, 9: a = AW'(KEYA);
                5: a = AW'(KSTAT);
                6, 7: a = AW'(POSB + $urandom_range(0, 2 * NP + 1));
                default: a = AW'($urandom);
            endcase
            for (int p = 0; p < NP; p++) begin
                case ($urandom_range(0, 6))
                    0, 1, 2, 3: {h_up[p], h_rt[p], h_dn[p], h_lf[p]} = 4'(4'b1000 >> $urandom_range(0, 3));
                    4: {h_up[p], h_rt[p], h_dn[p], h_lf[p]} = 4'b0000;
                    5: {h_up[p], h_rt[p], h_dn[p], h_lf[p]} = 4'($urandom);
                    default: ;
                endcase
            end
            h_kp = 1'($urandom_range(0, 1));
            h_kc = 8'($urandom);
            if (it == 450) do_reset();
            step(a, ($urandom_range(0, 3) == 0), $urandom);
        end

        h_kp = 0;
        repeat (3) step('0, 0, 0);
        @(negedge clock);
        chk("sb_drain", 32'(sb.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
